control_unit: RTL and testbench



---
 rtl/control_unit.sv | 117 +++++++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches from a 32-word ROM and walks each
// instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        zero_flag,
  input  logic        pos_flag,
  output logic        rf_write,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  rd_addr,
  output logic [15:0] imm_data,
  output logic [3:0]  alu_sel,
  output logic        imm_sel,
  output logic        mem_write,
  output logic [15:0] mem_data,
  output logic [4:0]  PC
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVI  = 4'hB;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_JZ    = 4'hE;
  localparam logic [3:0] OP_JP    = 4'hF;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        branch_taken;

  function automatic logic [15:0] rom_word(input logic [4:0] addr);
    case (addr)
      5'd0:    rom_word = 16'hB001;
      5'd1:    rom_word = 16'hB202;
      5'd2:    rom_word = 16'h0408;
      5'd3:    rom_word = 16'h1640;
      5'd4:    rom_word = 16'hBC08;
      5'd5:    rom_word = 16'hC180;
      5'd6:    rom_word = 16'hD006;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  assign opcode   = ir[15:12];
  assign mem_data = ir;

  // Branch decisions use the decoded opcode/immediate latched at DECODE
  assign branch_taken = (alu_sel == OP_JMP) ||
                        ((alu_sel == OP_JZ) && zero_flag) ||
                        ((alu_sel == OP_JP) && pos_flag);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    rf_write   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      INIT:      next_state = FETCH;
      FETCH:     next_state = DECODE;
      DECODE:    next_state = EXECUTE;
      EXECUTE:   next_state = WRITEBACK;
      WRITEBACK: begin
        next_state = FETCH;
        rf_write   = (alu_sel <= OP_MOVI);
        mem_write  = (alu_sel == OP_STORE);
      end
      default:   next_state = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir       <= 16'h0000;
      PC       <= 5'd0;
      rs_addr  <= 3'd0;
      rt_addr  <= 3'd0;
      rd_addr  <= 3'd0;
      imm_data <= 16'h0000;
      alu_sel  <= 4'h0;
      imm_sel  <= 1'b0;
    end else begin
      case (state)
        INIT, WRITEBACK: begin
          ir <= rom_word(PC);
          PC <= PC + 5'd1;
        end
        FETCH: begin
          rd_addr  <= ir[11:9];
          rs_addr  <= ir[8:6];
          rt_addr  <= ir[5:3];
          imm_data <= {{10{ir[5]}}, ir[5:0]};
          alu_sel  <= opcode;
          imm_sel  <= (opcode == 4'h8) || (opcode == 4'h9) ||
                      (opcode == OP_MOVI) || (opcode == OP_STORE);
        end
        EXECUTE: begin
          if (branch_taken) PC <= imm_data[4:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a reference instruction model pushes expected
// per-instruction results at FETCH and pops them for comparison at WRITEBACK.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        zero_flag = 1'b0;
  logic        pos_flag = 1'b0;
  logic        rf_write, imm_sel, mem_write;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data, mem_data;
  logic [3:0]  alu_sel;
  logic [4:0]  PC;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  alu;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
    logic        isel;
    logic        rfw;
    logic        mw;
    logic [4:0]  pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] rom [32];
  logic [4:0]  pc_m;
  logic [15:0] force_val;

  control_unit dut (
    .clock(clock), .reset(reset), .zero_flag(zero_flag), .pos_flag(pos_flag),
    .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel),
    .mem_write(mem_write), .mem_data(mem_data), .PC(PC)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #3;
    @(negedge clock);
    reset = 1'b1;
    pc_m  = 5'd0;
    q.delete();
  endtask

  task automatic run_instr(input bit do_force, input logic [15:0] fv);
    logic [15:0] ir_m;
    logic [3:0]  op;
    logic [4:0]  pc_seq;
    exp_t        e;
    exp_t        got;
    // FETCH
    step();
    ir_m = rom[pc_m];
    pc_m = pc_m + 5'd1;
    pc_seq = pc_m;
    vectors++;
    if ({PC, mem_data, rf_write, mem_write} !== {pc_m, ir_m, 2'b00}) begin
      miscompares++;
      $display("FAIL fetch: got PC=%0d ir=%h rf=%b mw=%b, want PC=%0d ir=%h rf=0 mw=0",
               PC, mem_data, rf_write, mem_write, pc_m, ir_m);
    end
    if (do_force) begin
      force_val = fv;
      force dut.ir = force_val;
      ir_m = fv;
    end
    op       = ir_m[15:12];
    e.alu    = op;
    e.rd     = ir_m[11:9];
    e.rs     = ir_m[8:6];
    e.rt     = ir_m[5:3];
    e.imm    = {{10{ir_m[5]}}, ir_m[5:0]};
    e.isel   = (op == 4'h8) || (op == 4'h9) || (op == 4'hB) || (op == 4'hC);
    e.rfw    = (op <= 4'hB);
    e.mw     = (op == 4'hC);
    e.pc     = ((op == 4'hD) || ((op == 4'hE) && zero_flag) || ((op == 4'hF) && pos_flag))
               ? ir_m[4:0] : pc_m;
    pc_m     = e.pc;
    q.push_back(e);
    // DECODE
    step();
    if (do_force) release dut.ir;
    vectors++;
    if ({alu_sel, rd_addr, rs_addr, rt_addr, imm_data, imm_sel, rf_write, mem_write} !==
        {e.alu, e.rd, e.rs, e.rt, e.imm, e.isel, 2'b00}) begin
      miscompares++;
      $display("FAIL decode: got alu=%h rd=%0d rs=%0d rt=%0d imm=%h isel=%b rf=%b mw=%b, want alu=%h rd=%0d rs=%0d rt=%0d imm=%h isel=%b rf=0 mw=0",
               alu_sel, rd_addr, rs_addr, rt_addr, imm_data, imm_sel, rf_write, mem_write,
               e.alu, e.rd, e.rs, e.rt, e.imm, e.isel);
    end
    // EXECUTE
    step();
    vectors++;
    if ({PC, rf_write, mem_write} !== {pc_seq, 2'b00}) begin
      miscompares++;
      $display("FAIL execute: got PC=%0d rf=%b mw=%b, want PC=%0d rf=0 mw=0",
               PC, rf_write, mem_write, pc_seq);
    end
    // WRITEBACK
    step();
    got = {alu_sel, rd_addr, rs_addr, rt_addr, imm_data, imm_sel, rf_write, mem_write, PC};
    e = q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL writeback: got alu=%h rd=%0d rs=%0d rt=%0d imm=%h isel=%b rf=%b mw=%b PC=%0d, want alu=%h rd=%0d rs=%0d rt=%0d imm=%h isel=%b rf=%b mw=%b PC=%0d",
               got.alu, got.rd, got.rs, got.rt, got.imm, got.isel, got.rfw, got.mw, got.pc,
               e.alu, e.rd, e.rs, e.rt, e.imm, e.isel, e.rfw, e.mw, e.pc);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({PC, rf_write, mem_write, alu_sel, mem_data, imm_data} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got PC=%0d rf=%b mw=%b alu=%h ir=%h imm=%h, want all 0",
               PC, rf_write, mem_write, alu_sel, mem_data, imm_data);
    end
    apply_reset();
    for (int i = 0; i < 3; i++) run_instr(1'b0, 16'h0000);
    // Now in WRITEBACK of the ADD: strobe is up; reset must kill it at once
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({PC, rf_write, mem_write, alu_sel, mem_data, rd_addr} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_async: got PC=%0d rf=%b mw=%b alu=%h ir=%h rd=%0d, want all 0",
               PC, rf_write, mem_write, alu_sel, mem_data, rd_addr);
    end
    step();
    vectors++;
    if ({PC, rf_write, mem_write, mem_data} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_edge: got PC=%0d rf=%b mw=%b ir=%h, want all 0",
               PC, rf_write, mem_write, mem_data);
    end
  endtask

  task automatic test_program();
    apply_reset();
    for (int i = 0; i < 6; i++) run_instr(1'b0, 16'h0000);
    vectors++;
    if ({mem_write, rf_write, rs_addr, mem_data} !== {1'b1, 1'b0, 3'd6, 16'hC180}) begin
      miscompares++;
      $display("FAIL store_wb: got mw=%b rf=%b rs=%0d ir=%h, want mw=1 rf=0 rs=6 ir=c180",
               mem_write, rf_write, rs_addr, mem_data);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) run_instr(1'b0, 16'h0000);
    vectors++;
    if ({PC, mem_data} !== {5'd6, 16'hD006}) begin
      miscompares++;
      $display("FAIL halt_loop: got PC=%0d ir=%h, want PC=6 ir=d006", PC, mem_data);
    end
  endtask

  task automatic test_branch(input logic [3:0] op, input logic z, input logic p);
    zero_flag = z;
    pos_flag  = p;
    apply_reset();
    for (int i = 0; i < 6; i++) run_instr(1'b0, 16'h0000);
    run_instr(1'b1, {op, 12'h00A});
    run_instr(1'b0, 16'h0000);
    zero_flag = 1'b0;
    pos_flag  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = 16'hB001; rom[1] = 16'hB202; rom[2] = 16'h0408; rom[3] = 16'h1640;
    rom[4] = 16'hBC08; rom[5] = 16'hC180; rom[6] = 16'hD006;
    pc_m = 5'd0;
    force_val = 16'h0000;
    test_reset();
    test_program();
    test_halt();
    test_branch(4'hE, 1'b1, 1'b0);
    test_branch(4'hE, 1'b0, 1'b1);
    test_branch(4'hF, 1'b0, 1'b1);
    test_branch(4'hF, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
